// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled pins, MSB-first rx/tx shift, valid/ready word output.
// Define SPI_SLAVE_RX_OVR_EN to enable the sticky overrun flag.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_h, ss_h;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [DATA_W-1:0] rx, tx, rx_next;
  logic [CW-1:0]     cnt;
  logic              done;
  logic              start, stop, shift_in, shift_out;
  logic              last_bit, word_end;

  // ss synchronisers reset high so a reset never looks like a select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sclk_h <= 1'b0;
      ss_h   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_h <= sclk_s;
      ss_h   <= ss_s;
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_h;
  assign sclk_fall = ~sclk_s & sclk_h;
  assign ss_fall   = ss_h & ~ss_s;
  assign ss_rise   = ~ss_h & ss_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    stop      = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_n = IDLE;
          stop    = 1'b1;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
    endcase
  end

  assign last_bit = (cnt == CW'(DATA_W - 1));
  assign rx_next  = {rx[DATA_W-2:0], mosi_s};
  assign word_end = shift_in & last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx   <= '0;
      tx   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      rx   <= '0;
      tx   <= tdata;
      cnt  <= '0;
      done <= 1'b0;
    end else if (stop) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      if (shift_in) begin
        rx <= rx_next;
        if (last_bit) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      // first fall after a completed word presents the next tdata MSB
      if (shift_out) begin
        if (cnt == '0 && done) begin
          tx   <= tdata;
          done <= 1'b0;
        end else begin
          tx <= tx << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (word_end) begin
      rdata  <= rx_next;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_RX_OVR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (word_end && rvalid && !rready)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  assign miso = (state == ACTIVE) & tx[DATA_W-1];
  assign busy = ~ss_s;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: pin-level SPI master plus word-level queue model.
module tb_spi_slave_rx;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tdata = 8'h00;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       busy;
  logic       overrun;

  logic rready_fix = 1'b1;
  logic rr_rand = 1'b0;
  logic rnd = 1'b0;
  assign rready = rnd ? rr_rand : rready_fix;

  int   pass_cnt = 0;
  int   total = 0;
  int   rv_cycles = 0;
  logic exp_ovr = 1'b0;

  logic [7:0] q[$];
  logic [7:0] got_w[4];
  logic [7:0] mo_a[4];
  logic [7:0] td_a[4];

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .tdata(tdata), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one register of storage: a new word replaces an unconsumed one
  function automatic void model_word(input logic [7:0] w);
    if (q.size() > 0) begin
      q.delete(0);
`ifdef SPI_SLAVE_RX_OVR_EN
      exp_ovr = 1'b1;
`endif
    end
    q.push_back(w);
  endfunction

  initial forever begin
    @(negedge clk);
    if (!reset && rvalid) rv_cycles++;
    if (!reset && rvalid && rready) begin
      if (q.size() == 0) check("spurious_rvalid", q.size(), 1);
      else begin
        check("rdata", rdata, q[0]);
        q.delete(0);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rr_rand = 1'($urandom_range(0, 1));
  end

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) wait_clk(1);
    check("drain", q.size(), 0);
  endtask

  task automatic frame(input int n, input int cut);
    logic [7:0] got;
    int bits;
    bits = (cut > 0) ? cut : 8;
    tdata = td_a[0];
    wait_clk(1);
    ss = 1'b0;
    for (int w = 0; w < n; w++) begin
      got = 8'h00;
      for (int b = 0; b < bits; b++) begin
        mosi = mo_a[w][7-b];
        wait_clk(HALF);
        sclk = 1'b1;
        got = {got[6:0], miso};
        check("busy", busy, 1);
        if (b == 7) model_word(mo_a[w]);
        wait_clk(HALF);
        if (b == 7 && w + 1 < n) tdata = td_a[w+1];
        sclk = 1'b0;
      end
      if (cut == 0) begin
        got_w[w] = got;
        check("miso_word", got, td_a[w]);
      end
    end
    wait_clk(HALF);
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(2 * HALF);
    check("idle_miso", miso, 0);
    check("idle_busy", busy, 0);
    if (rnd || rready_fix) drain();
    check("overrun", overrun, exp_ovr);
  endtask

  initial begin
    wait_clk(2);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    wait_clk(4);

    rv_cycles = 0;
    mo_a[0] = 8'h05; td_a[0] = 8'h00;
    frame(1, 0);
    check("t1_rdata", rdata, 8'h05);
    check("t1_pulse", rv_cycles, 1);

    mo_a[0] = 8'h00; td_a[0] = 8'hA5;
    frame(1, 0);
    check("t2_miso", got_w[0], 8'hA5);
    check("t2_rdata", rdata, 8'h00);

    mo_a[0] = 8'h05; mo_a[1] = 8'h3C;
    td_a[0] = 8'hA5; td_a[1] = 8'h81;
    frame(2, 0);
    check("t3_miso0", got_w[0], 8'hA5);
    check("t3_miso1", got_w[1], 8'h81);
    check("t3_rdata", rdata, 8'h3C);

    rv_cycles = 0;
    mo_a[0] = 8'hFF; td_a[0] = 8'h00;
    frame(1, 4);
    check("t4_no_rvalid", rv_cycles, 0);
    mo_a[0] = 8'hC3;
    frame(1, 0);
    check("t4_rdata", rdata, 8'hC3);

    rready_fix = 1'b0;
    mo_a[0] = 8'h11; mo_a[1] = 8'h22;
    td_a[0] = 8'h00; td_a[1] = 8'h00;
    frame(2, 0);
    wait_clk(4);
    check("t5_rdata", rdata, 8'h22);
    check("t5_rvalid", rvalid, 1);
`ifdef SPI_SLAVE_RX_OVR_EN
    check("t5_overrun", overrun, 1);
`else
    check("t5_overrun", overrun, 0);
`endif
    rready_fix = 1'b1;
    drain();

    tdata = 8'hFF;
    ss = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'b1;
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(2);
    reset = 1'b1;
    #1;
    check("t6_rdata", rdata, 0);
    check("t6_rvalid", rvalid, 0);
    check("t6_miso", miso, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    q.delete();
    exp_ovr = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(4 * HALF);
    mo_a[0] = 8'h5A; td_a[0] = 8'h3C;
    frame(1, 0);
    check("t6_rdata_after", rdata, 8'h5A);

    rnd = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int n;
      int cut;
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        mo_a[k] = 8'($urandom);
        td_a[k] = 8'($urandom);
      end
      cut = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      if (cut > 0) n = 1;
      if ($urandom_range(0, 2) == 0) begin
        repeat (3) begin
          mosi = 1'($urandom_range(0, 1));
          sclk = 1'b1;
          wait_clk(HALF);
          sclk = 1'b0;
          wait_clk(HALF);
        end
        mosi = 1'b0;
      end
      frame(n, cut);
    end
    rnd = 1'b0;
    wait_clk(4);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI slave receiver/transmitter sitting directly downstream of the SPI `master` on the `mosi`/`sclk`/`ss` wires. It oversamples the SPI pins in the system clock domain, shifts in 8-bit words MSB-first, and presents each completed word on a valid/ready handshake. It simultaneously shifts a user-supplied word out on `miso` in SPI mode 0 (CPOL=0, CPHA=0).

## Interface
- `DATA_W`, 8: word width in bits (shift length).
- `SYNC_STAGES`, 2: synchroniser flops on `sclk`, `ss`, `mosi` (min 2).
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sclk` in 1: SPI clock from master, asynchronous to `clk`, idle low.
- `ss` in 1: slave select, active low, asynchronous.
- `mosi` in 1: serial data from master.
- `miso` out 1: serial data to master.
- `tdata` in DATA_W: word to transmit; sampled at frame/word start.
- `rdata` out DATA_W: last received word.
- `rvalid` out 1: `rdata` holds an unconsumed word.
- `rready` in 1: consumer accepts `rdata` when `rvalid & rready`.
- `busy` out 1: synchronised `ss` is low (frame in progress).
- `overrun` out 1: sticky, word lost (only with `SPI_SLAVE_RX_OVR_EN`).

## Operation
- Pins pass through `SYNC_STAGES` flops, then one history flop; edges detected from (history, synced) pair.
- States: IDLE (ss high) and ACTIVE (ss low). IDLE->ACTIVE on detected `ss` fall; ACTIVE->IDLE on detected `ss` rise.
- On `ss` fall: load `tdata` into tx shift register, clear bit counter to 0, clear rx shift register.
- Detected `sclk` rise (ACTIVE only): shift synced `mosi` into rx register LSB, counter += 1.
- When counter reaches DATA_W on a rise: copy rx register (including that bit) to `rdata`, set `rvalid`, counter wraps to 0.
- Detected `sclk` fall (ACTIVE): if counter is 0 and a word just completed, reload tx register from `tdata`; else shift tx register left by one.
- `miso` = tx register MSB while ACTIVE; 0 while IDLE.
- `rvalid` clears on `rvalid & rready`; set takes priority over clear in the same cycle.
- `ss` rise with counter != 0: partial word discarded, no `rvalid`, counter cleared.
- `sclk` edges while IDLE ignored.
- Reset (any time, incl. mid-frame): state IDLE, counter 0, shift registers 0, `rdata`=0, `rvalid`=0, `miso`=0, `busy`=0, `overrun`=0, sync flops 0 except `ss` sync flops 1.

## Timing
- Pin-to-edge-detect latency: `SYNC_STAGES`+1 `clk` cycles (3 by default).
- `rvalid` rises `SYNC_STAGES`+2 cycles after the pin-level DATA_W-th `sclk` rise.
- `sclk` high and low phases each >= `SYNC_STAGES`+2 `clk` periods; `ss` fall to first `sclk` rise >= same.
- First `miso` bit valid `SYNC_STAGES`+2 cycles after `ss` fall; subsequent bits change that many cycles after `sclk` fall.
- `tdata` must be stable from `ss` fall (and from each word's last `sclk` fall) until sampled.

## Configuration
- `SPI_SLAVE_RX_OVR_EN` defined: word completing while `rvalid`=1 and not accepted that cycle overwrites `rdata` and sets `overrun`; `overrun` clears only on `reset`.
- Not defined: overwrite still occurs; `overrun` tied to 0, no flag logic.

## Test plan
- Master sends 0x05 with `rready`=1 -> one-cycle `rvalid` pulse, `rdata`=0x05, `busy` high for whole frame.
- `tdata`=0xA5, master sends 0x00 -> master samples `miso` bits 1,0,1,0,0,1,0,1; `miso`=0 after `ss` high.
- `ss` held low, bytes 0x05 then 0x3C, `tdata` changed 0xA5->0x81 after first word -> `rdata` 0x05 then 0x3C; `miso` sends 0xA5 then 0x81.
- `ss` raised after 4 `sclk` rises -> no `rvalid`; next full frame of 0xC3 -> `rdata`=0xC3.
- `rready`=0, two words 0x11, 0x22 -> `rdata`=0x22, `rvalid`=1, `overrun`=1 with macro, 0 without.
- `reset` pulsed mid-byte (after 3 bits) -> all outputs 0 immediately; following clean frame 0x5A received correctly.
